// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle ADD/LW/SW core: opcodes, FSM states,
// ALU control codes and instruction field positions.
package proc_pkg;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b000010;
  localparam logic [5:0] OP_SW  = 6'b000100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010
  } alu_ctrl_t;

  // Instruction fields: A = rd (ADD) / rt (LW,SW), B = rs, C = rt (ADD only)
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned FA_MSB  = 25;
  localparam int unsigned FA_LSB  = 21;
  localparam int unsigned FB_MSB  = 20;
  localparam int unsigned FB_LSB  = 16;
  localparam int unsigned FC_MSB  = 15;
  localparam int unsigned FC_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous operand reads, one debug read, one
// synchronous write, asynchronous active-low clear. Optional hardwired r0.
module regfile #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_N     = 32,
  parameter int unsigned ZERO_REG0 = 0,
  localparam int unsigned AW       = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  // Sized to the full index space so out-of-range debug reads return the
  // cleared value; the core never writes an index of REG_N or above.
  logic [DATA_W-1:0] regs [2**AW];

  // Register storage: clear on reset, write port on the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (we && !(ZERO_REG0 != 0 && wa == '0)) begin
      regs[wa] <= wd;
    end
  end

  // Asynchronous read ports with optional r0 forced to zero
  always_comb begin
    ra_data  = regs[ra_addr];
    rb_data  = regs[rb_addr];
    dbg_data = regs[dbg_addr];
    if (ZERO_REG0 != 0) begin
      if (ra_addr == '0)  ra_data  = '0;
      if (rb_addr == '0)  rb_data  = '0;
      if (dbg_addr == '0) dbg_data = '0;
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle ADD/LW/SW core: IR latch, register file, data memory and a
// five-state control FSM (IDLE/DECODE/EXEC/MEM/WB).
module multicycle_core
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_N     = 32,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned ZERO_REG0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  output logic                     retire,
  output logic                     illegal,
  output logic [DATA_W-1:0]        data_out,
  output logic                     busy,
  input  logic [$clog2(REG_N)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned RA_W = $clog2(REG_N);
  localparam int unsigned MA_W = $clog2(MEM_DEPTH);

  state_t            state, state_nx;
  logic [31:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, alu_out, mdr;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [5:0]        opcode;
  logic [4:0]        f_a, f_b, f_c;
  logic              is_add, is_lw, is_sw, legal;
  logic [DATA_W-1:0] imm_ext, alu_in_b, alu_res, rf_a, rf_b, wb_data;
  alu_ctrl_t         alu_ctrl;
  logic [MA_W-1:0]   mem_addr;
  logic              rf_we;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < REG_N;
  endfunction

  // Instruction field decode and legality check from the latched IR
  always_comb begin
    opcode  = ir[OP_MSB:OP_LSB];
    f_a     = ir[FA_MSB:FA_LSB];
    f_b     = ir[FB_MSB:FB_LSB];
    f_c     = ir[FC_MSB:FC_LSB];
    is_add  = (opcode == OP_ADD);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    imm_ext = DATA_W'($signed(ir[IMM_MSB:IMM_LSB]));
    legal   = (is_add && idx_ok(f_a) && idx_ok(f_b) && idx_ok(f_c)) ||
              ((is_lw || is_sw) && idx_ok(f_a) && idx_ok(f_b));
  end

  // ALU: every legal instruction uses addition (sum or effective address)
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_in_b = is_add ? op_b : imm_ext;
    case (alu_ctrl)
      ALU_AND: alu_res = op_a & alu_in_b;
      ALU_OR:  alu_res = op_a | alu_in_b;
      ALU_ADD: alu_res = op_a + alu_in_b;
      default: alu_res = '0;
    endcase
  end

  // Writeback path: rd and rt share the A field, so one write index suffices
  always_comb begin
    mem_addr = alu_out[MA_W-1:0];
    rf_we    = (state == S_WB);
    wb_data  = is_add ? alu_out : mdr;
  end

  regfile #(
    .DATA_W    (DATA_W),
    .REG_N     (REG_N),
    .ZERO_REG0 (ZERO_REG0)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (f_b[RA_W-1:0]),
    .ra_data  (rf_a),
    .rb_addr  (is_add ? f_c[RA_W-1:0] : f_a[RA_W-1:0]),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (f_a[RA_W-1:0]),
    .wd       (wb_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state and handshake/retire outputs
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        busy        = 1'b0;
        instr_ready = rst;
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_nx = S_EXEC;
        end else begin
          retire   = 1'b1;
          illegal  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_EXEC: state_nx = is_add ? S_WB : S_MEM;
      S_MEM: begin
        if (is_lw) begin
          state_nx = S_WB;
        end else begin
          retire   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WB: begin
        retire   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers: IR, operand latches, ALU result, MDR, data_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        S_IDLE:   if (instr_valid) ir <= instr;
        S_DECODE: begin
          op_a <= rf_a;
          op_b <= rf_b;
        end
        S_EXEC:   alu_out <= alu_res;
        S_MEM: begin
          if (is_lw)      mdr      <= mem[mem_addr];
          else if (is_sw) data_out <= op_b;
        end
        S_WB:     data_out <= wb_data;
        default:  ;
      endcase
    end
  end

  // Data memory: reset to word index, written only at the end of an SW MEM cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (state == S_MEM && is_sw) begin
      mem[mem_addr] <= op_b;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Testbench for multicycle_core: two instances (REG_N=8 with normal r0, and
// REG_N=32 with hardwired r0) checked against an instruction-level model.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid [2];
  logic [31:0] instr       [2];
  logic        instr_ready [2];
  logic        retire      [2];
  logic        illegal     [2];
  logic        busy        [2];
  logic [31:0] data_out    [2];
  logic [4:0]  dbg_addr    [2];
  logic [31:0] dbg_data    [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_reg  [2][32];
  logic [31:0] m_mem  [2][16];
  logic [31:0] m_dout [2];

  always #5 clk = ~clk;

  multicycle_core #(
    .DATA_W    (32),
    .REG_N     (8),
    .MEM_DEPTH (16),
    .ZERO_REG0 (0)
  ) u_a (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid[0]),
    .instr_ready (instr_ready[0]),
    .instr       (instr[0]),
    .retire      (retire[0]),
    .illegal     (illegal[0]),
    .data_out    (data_out[0]),
    .busy        (busy[0]),
    .dbg_addr    (dbg_addr[0][2:0]),
    .dbg_data    (dbg_data[0])
  );

  multicycle_core #(
    .DATA_W    (32),
    .REG_N     (32),
    .MEM_DEPTH (16),
    .ZERO_REG0 (1)
  ) u_b (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid[1]),
    .instr_ready (instr_ready[1]),
    .instr       (instr[1]),
    .retire      (retire[1]),
    .illegal     (illegal[1]),
    .data_out    (data_out[1]),
    .busy        (busy[1]),
    .dbg_addr    (dbg_addr[1]),
    .dbg_data    (dbg_data[1])
  );

  function automatic logic [31:0] mk_add(input int rd, input int rs, input int rt);
    return {6'b000001, 5'(rd), 5'(rs), 5'(rt), 11'h0};
  endfunction

  function automatic logic [31:0] mk_lw(input int rt, input int rs, input logic [15:0] imm);
    return {6'b000010, 5'(rt), 5'(rs), imm};
  endfunction

  function automatic logic [31:0] mk_sw(input int rt, input int rs, input logic [15:0] imm);
    return {6'b000100, 5'(rt), 5'(rs), imm};
  endfunction

  function automatic int reg_n(input int d);
    return (d == 0) ? 8 : 32;
  endfunction

  function automatic logic [31:0] rv(input int d, input int i);
    if (d == 1 && i == 0) return 32'h0;
    return m_reg[d][i];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_reg[d][i] = 32'h0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = 32'(i);
      m_dout[d] = 32'h0;
    end
  endtask

  // Architectural effect of one instruction, plus its expected latency
  task automatic model_exec(input int d, input logic [31:0] ins, output int lat, output bit ill);
    int          op, a, b, c, addr;
    logic [31:0] sext, v;
    op   = int'(ins[31:26]);
    a    = int'(ins[25:21]);
    b    = int'(ins[20:16]);
    c    = int'(ins[15:11]);
    sext = {{16{ins[15]}}, ins[15:0]};
    addr = int'((rv(d, b) + sext) % 16);
    ill  = 1'b1;
    lat  = 1;
    if (op == 1 && a < reg_n(d) && b < reg_n(d) && c < reg_n(d)) begin
      v = rv(d, b) + rv(d, c);
      if (!(d == 1 && a == 0)) m_reg[d][a] = v;
      m_dout[d] = v;
      ill = 1'b0;
      lat = 3;
    end else if (op == 2 && a < reg_n(d) && b < reg_n(d)) begin
      v = m_mem[d][addr];
      if (!(d == 1 && a == 0)) m_reg[d][a] = v;
      m_dout[d] = v;
      ill = 1'b0;
      lat = 4;
    end else if (op == 4 && a < reg_n(d) && b < reg_n(d)) begin
      m_mem[d][addr] = rv(d, a);
      m_dout[d] = rv(d, a);
      ill = 1'b0;
      lat = 3;
    end
  endtask

  // Issue one instruction on instance d and check handshake, latency and result
  task automatic run_instr(input int d, input logic [31:0] ins, input bit hold_valid);
    int lat, n, w;
    bit ill, got;
    w = 0;
    while (!instr_ready[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready[d]) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_wait d=%0d instr=%h: instr_ready stayed %b, required 1", d, ins, instr_ready[d]);
      return;
    end
    instr_valid[d] = 1'b1;
    instr[d]       = ins;
    @(posedge clk);
    #1;
    instr[d]       = $urandom;
    instr_valid[d] = hold_valid;
    model_exec(d, ins, lat, ill);
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (retire[d]) begin
        got = 1'b1;
      end else begin
        n_cmp++;
        if (instr_ready[d] !== 1'b0 || busy[d] !== 1'b1 || illegal[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_cycle d=%0d instr=%h cyc=%0d: ready=%b busy=%b illegal=%b, required 0/1/0",
                   d, ins, n, instr_ready[d], busy[d], illegal[d]);
        end
      end
    end
    instr_valid[d] = 1'b0;
    n_cmp++;
    if (!got || n != lat) begin
      n_fail++;
      $display("FAIL latency d=%0d instr=%h: got %0d (retired=%b), required %0d", d, ins, n, got, lat);
    end
    if (got) begin
      n_cmp++;
      if (illegal[d] !== ill) begin
        n_fail++;
        $display("FAIL illegal_flag d=%0d instr=%h: got %b, required %b", d, ins, illegal[d], ill);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (data_out[d] !== m_dout[d]) begin
      n_fail++;
      $display("FAIL data_out d=%0d instr=%h: got %h, required %h", d, ins, data_out[d], m_dout[d]);
    end
    n_cmp++;
    if (instr_ready[d] !== 1'b1 || retire[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_idle d=%0d instr=%h: ready=%b retire=%b, required 1/0", d, ins, instr_ready[d], retire[d]);
    end
  endtask

  task automatic check_regs(input int d);
    for (int i = 0; i < reg_n(d); i++) begin
      dbg_addr[d] = 5'(i);
      #1;
      n_cmp++;
      if (dbg_data[d] !== rv(d, i)) begin
        n_fail++;
        $display("FAIL regfile d=%0d r%0d: got %h, required %h", d, i, dbg_data[d], rv(d, i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (retire[d] !== 1'b0 || illegal[d] !== 1'b0 || busy[d] !== 1'b0 || data_out[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs d=%0d: retire=%b illegal=%b busy=%b data_out=%h, required 0/0/0/0",
                 d, retire[d], illegal[d], busy[d], data_out[d]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (instr_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready d=%0d: got %b, required 1", d, instr_ready[d]);
      end
      check_regs(d);
    end
  endtask

  task automatic test_directed();
    run_instr(0, mk_lw(1, 0, 16'd3), 1'b0);
    run_instr(0, mk_lw(2, 0, 16'd5), 1'b0);
    run_instr(0, mk_add(4, 1, 2), 1'b0);
    run_instr(0, mk_sw(4, 0, 16'd1), 1'b0);
    run_instr(0, mk_lw(5, 0, 16'd1), 1'b0);
    run_instr(0, mk_lw(3, 1, 16'hFFFF), 1'b0);
    run_instr(0, mk_lw(6, 0, 16'd15), 1'b0);
    run_instr(0, mk_lw(7, 6, 16'd2), 1'b0);
    check_regs(0);
  endtask

  task automatic test_illegal();
    run_instr(0, {6'b111111, 26'h1234567}, 1'b0);
    check_regs(0);
    run_instr(0, mk_add(9, 1, 2), 1'b0);
    run_instr(0, mk_lw(2, 12, 16'd0), 1'b0);
    run_instr(0, mk_sw(8, 0, 16'd0), 1'b0);
    run_instr(1, {6'b000000, 26'h0}, 1'b0);
    check_regs(0);
  endtask

  task automatic test_zero_reg();
    run_instr(1, mk_lw(0, 0, 16'd3), 1'b0);
    run_instr(1, mk_lw(9, 0, 16'd6), 1'b0);
    run_instr(1, mk_add(0, 9, 9), 1'b0);
    run_instr(1, mk_add(10, 0, 9), 1'b0);
    check_regs(1);
  endtask

  task automatic test_busy_ignore();
    run_instr(0, mk_add(3, 4, 5), 1'b1);
    run_instr(0, mk_lw(6, 3, 16'h0002), 1'b1);
    run_instr(0, mk_sw(6, 1, 16'h0007), 1'b1);
    check_regs(0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++) begin
      int          d, sel, a, b, c;
      logic [31:0] ins;
      logic [15:0] imm;
      d   = k % 2;
      sel = $urandom_range(0, 9);
      a   = (d == 0) ? $urandom_range(0, 8) : $urandom_range(0, 31);
      b   = (d == 0) ? $urandom_range(0, 8) : $urandom_range(0, 31);
      c   = (d == 0) ? $urandom_range(0, 8) : $urandom_range(0, 31);
      imm = 16'($urandom);
      if (sel < 3)      ins = mk_add(a, b, c);
      else if (sel < 6) ins = mk_lw(a, b, imm);
      else if (sel < 9) ins = mk_sw(a, b, imm);
      else              ins = $urandom;
      run_instr(d, ins, $urandom_range(0, 1) == 1);
    end
    check_regs(0);
    check_regs(1);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ill;
    run_instr(0, mk_lw(4, 0, 16'd7), 1'b0);
    run_instr(0, mk_add(4, 4, 4), 1'b0);
    instr_valid[0] = 1'b1;
    instr[0]       = mk_sw(4, 0, 16'd0);
    @(posedge clk);
    #1;
    instr_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b, required 1", busy[0]);
    end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_regs(0);
    check_regs(1);
    run_instr(0, mk_lw(1, 0, 16'd0), 1'b0);
    run_instr(0, mk_lw(2, 0, 16'd7), 1'b0);
    run_instr(1, mk_lw(0, 0, 16'd3), 1'b0);
    check_regs(1);
    lat = 0;
    ill = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      instr_valid[d] = 1'b0;
      instr[d]       = 32'h0;
      dbg_addr[d]    = 5'h0;
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_zero_reg();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
